layer_ram_reader: RTL and testbench

- Read-side engine for the dual-port layer_ram. It drives port B (enb/addrb) and captures doutb.
- It streams a contiguous block of 16-bit feature-map words to downstream compute logic over a valid/ready interface.
- It is the counterpart of the port-A writer that loads PCIe data into layer_ram. It hides the RAM read latency and absorbs backpressure with a small credit-controlled buffer.

---
 rtl/layer_ram_reader_pkg.sv | 14 +
 rtl/layer_ram_reader_if.sv | 14 +
 rtl/layer_ram_reader_fifo.sv | 46 ++++
 rtl/layer_ram_reader.sv | 140 ++++++++++++++
 tb/tb_layer_ram_reader.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/layer_ram_reader_pkg.sv
// Shared widths and FSM encoding for the layer_ram port-B read engine.
package layer_ram_reader_pkg;

    localparam int ADDR_W_DEF = 19;
    localparam int DATA_W_DEF = 16;
    localparam int LEN_W_DEF  = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/layer_ram_reader_if.sv
// Valid/ready word stream from the layer_ram reader to downstream compute.
interface layer_ram_reader_if
    import layer_ram_reader_pkg::*;
#(
    parameter int DW = DATA_W_DEF
);
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/layer_ram_reader_fifo.sv
// First-word-fall-through FIFO: the head word sits on dout_o whenever !empty_o.
module sync_fifo_fwft #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [PW:0]                 count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_i && !pop_i)      count_q <= count_q + 1'b1;
            else if (!push_i && pop_i) count_q <= count_q - 1'b1;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/layer_ram_reader.sv
// Streams a contiguous block of layer_ram words out of port B, hiding RAM latency
// behind a credit-limited FWFT buffer so downstream backpressure never drops data.
module layer_ram_reader
    import layer_ram_reader_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_W_DEF,
    parameter int DATA_WIDTH   = DATA_W_DEF,
    parameter int LEN_WIDTH    = LEN_W_DEF,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  enb,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] doutb,
    layer_ram_reader_if.master    m
);
    localparam int CW = $clog2(FIFO_DEPTH);
    localparam logic [CW+1:0] DEPTH_C = (CW+2)'(FIFO_DEPTH);

    rd_state_e               state_q;
    logic                    enb_q, busy_q, done_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_WIDTH-1:0]    len_q, issued_q, beat_q;
    logic [CW:0]             inflight_q;
    logic [READ_LATENCY-1:0] vld_pipe_q;

    logic                    push, pop, issue, credit_ok, last_beat;
    logic                    fifo_full, fifo_empty;
    logic [CW:0]             fifo_cnt;
    logic [CW+1:0]           used;
    logic [DATA_WIDTH-1:0]   fifo_dout;

    assign push      = vld_pipe_q[READ_LATENCY-1];
    assign pop       = !fifo_empty && m.m_ready;
    assign last_beat = (beat_q == len_q - 1'b1);

    // Credit uses the post-pop occupancy; a same-edge push just moves a read
    // from in-flight into the FIFO, so it cancels out.
    assign used      = {1'b0, fifo_cnt} + {1'b0, inflight_q} - {{(CW+1){1'b0}}, pop};
    assign credit_ok = (used < DEPTH_C);

    always_comb begin
        issue = 1'b0;
        case (state_q)
            IDLE:    issue = start && (length != '0);
            RUN:     issue = (issued_q != len_q) && credit_ok;
            default: issue = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            enb_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            beat_q     <= '0;
            inflight_q <= '0;
            vld_pipe_q <= '0;
        end else begin
            enb_q         <= issue;
            done_q        <= 1'b0;
            vld_pipe_q[0] <= enb_q;
            for (int i = 1; i < READ_LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
            inflight_q <= inflight_q + {{CW{1'b0}}, issue} - {{CW{1'b0}}, push};
            if (pop) beat_q <= beat_q + 1'b1;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q  <= RUN;
                            busy_q   <= 1'b1;
                            addr_q   <= base_addr;
                            len_q    <= length;
                            issued_q <= {{(LEN_WIDTH-1){1'b0}}, 1'b1};
                            beat_q   <= '0;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr_q   <= addr_q + 1'b1;
                        issued_q <= issued_q + 1'b1;
                    end else if (issued_q == len_q) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Accepting the last beat implies the FIFO and read pipe are empty.
                    if (pop && last_beat) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sync_fifo_fwft #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (doutb),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign enb       = enb_q;
    assign addrb     = addr_q;
    assign m.m_valid = !fifo_empty;
    assign m.m_data  = fifo_dout;
    assign m.m_last  = !fifo_empty && last_beat;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_layer_ram_reader.sv
// Scoreboard bench for layer_ram_reader with a latency-1 behavioural port-B RAM.
module tb_layer_ram_reader;
    localparam int AW = 19;
    localparam int DW = 16;
    localparam int LW = 20;
    localparam int RL = 1;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] length = '0;
    logic          busy, done, enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb = '0;

    layer_ram_reader_if #(.DW(DW)) s ();

    always #5 clk = ~clk;

    layer_ram_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
        .READ_LATENCY(RL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done), .enb(enb), .addrb(addrb),
        .doutb(doutb), .m(s)
    );

    logic [DW-1:0] ram [logic [AW-1:0]];

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        if (ram.exists(a)) return ram[a];
        return a[15:0] ^ 16'h5A3C;
    endfunction

    always @(posedge clk) if (enb) doutb <= rd(addrb);

    int errs = 0, checks = 0;
    int cyc_n = 0, xt0 = 0;
    int first_enb, first_vld, last_beat, done_at, done_cnt = 0;
    int beats = 0, issued_n = 0, max_out = 0;
    logic busy_seen = 1'b0, mon_en = 1'b0, stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;
    logic [DW-1:0] exp_d[$];
    logic [AW-1:0] exp_a[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic monitor();
        if (enb) begin
            issued_n++;
            if (first_enb < 0) first_enb = cyc_n;
            if (exp_a.size() == 0) chk("enb_extra", 32'(1), 32'(0));
            else chk("addrb", 32'(addrb), 32'(exp_a.pop_front()));
        end
        if (issued_n - beats > max_out) max_out = issued_n - beats;
        if (busy) busy_seen = 1'b1;
        if (stall_prev) begin
            chk("stall_valid", 32'(s.m_valid), 32'(1));
            chk("stall_data", 32'(s.m_data), 32'(stall_data));
        end
        if (s.m_valid && first_vld < 0) first_vld = cyc_n;
        if (s.m_valid && s.m_ready) begin
            beats++;
            last_beat = cyc_n;
            if (exp_d.size() == 0) chk("beat_extra", 32'(1), 32'(0));
            else begin
                chk("m_data", 32'(s.m_data), 32'(exp_d.pop_front()));
                chk("m_last", 32'(s.m_last), 32'(exp_d.size() == 0));
            end
        end
        if (done) begin
            done_cnt++;
            done_at = cyc_n;
            chk("busy_at_done", 32'(busy), 32'(0));
        end
        stall_prev = s.m_valid && !s.m_ready;
        stall_data = s.m_data;
    endtask

    task automatic cyc(input logic rdy);
        s.m_ready = rdy;
        if (mon_en) monitor();
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc_n++;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1-0-0-1. inj>0 pulses a
    // competing start on that cycle of the transfer.
    task automatic xfer(input logic [AW-1:0] b, input logic [LW-1:0] n,
                        input int mode, input int inj);
        int d0, budget;
        for (int i = 0; i < int'(n); i++) begin
            exp_a.push_back(b + AW'(i));
            exp_d.push_back(rd(b + AW'(i)));
        end
        base_addr = b; length = n; start = 1'b1;
        first_enb = -1; first_vld = -1; last_beat = -1; done_at = -1;
        beats = 0; issued_n = 0; max_out = 0; busy_seen = 1'b0;
        d0 = done_cnt; xt0 = cyc_n; budget = 0;
        while (done_cnt == d0 && budget < 400) begin
            if (inj > 0 && budget == inj) begin
                base_addr = 19'h200; length = 20'd5; start = 1'b1;
            end
            cyc((mode == 0) ? 1'b1 : ((budget % 4) == 0 || (budget % 4) == 3));
            budget++;
        end
        chk("done_timeout", 32'(budget < 400), 32'(1));
        repeat (3) cyc(1'b1);
        chk("done_once", 32'(done_cnt - d0), 32'(1));
        chk("beat_count", 32'(beats), 32'(n));
        chk("exp_left", 32'(exp_d.size()), 32'(0));
        chk("busy_seen", 32'(busy_seen), 32'(n != 0));
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_busy"},   32'(busy),      32'(0));
        chk({pfx, "_done"},   32'(done),      32'(0));
        chk({pfx, "_enb"},    32'(enb),       32'(0));
        chk({pfx, "_addrb"},  32'(addrb),     32'(0));
        chk({pfx, "_mvalid"}, 32'(s.m_valid), 32'(0));
        chk({pfx, "_mlast"},  32'(s.m_last),  32'(0));
        chk({pfx, "_mdata"},  32'(s.m_data),  32'(0));
    endtask

    initial begin
        int b;
        s.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst");
        rst_n = 1'b1;
        mon_en = 1'b1;
        cyc(1'b1);

        // basic transfer
        ram[19'h0] = 16'h3C00; ram[19'h1] = 16'h4000; ram[19'h2] = 16'h4200;
        xfer(19'h0, 20'd3, 0, 0);
        chk("b_first_enb", 32'(first_enb), 32'(xt0 + 1));
        chk("b_first_vld", 32'(first_vld), 32'(xt0 + 2 + RL));
        chk("b_consec",    32'(last_beat), 32'(first_vld + 2));
        chk("b_done_lat",  32'(done_at),   32'(last_beat + 1));

        // backpressure
        xfer(19'h40, 20'd16, 1, 0);
        chk("bp_outstanding", 32'(max_out <= FD), 32'(1));

        // zero length
        xfer(19'h10, 20'd0, 0, 0);
        chk("z_done_lat", 32'(done_at), 32'(xt0 + 1));
        chk("z_no_enb",   32'(first_enb < 0), 32'(1));
        chk("z_no_vld",   32'(first_vld < 0), 32'(1));

        // address wrap
        xfer(19'h7FFFE, 20'd4, 0, 0);

        // reset mid-transfer
        for (int i = 0; i < 10; i++) begin
            exp_a.push_back(AW'(i));
            exp_d.push_back(rd(AW'(i)));
        end
        base_addr = '0; length = 20'd10; start = 1'b1;
        beats = 0; issued_n = 0;
        b = 0;
        while (beats < 5 && b < 100) begin cyc(1'b1); b++; end
        chk("r_reach_beat5", 32'(beats), 32'(5));
        #2 rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        exp_a.delete(); exp_d.delete(); stall_prev = 1'b0;
        cyc(1'b1); cyc(1'b1);
        rst_n = 1'b1;
        cyc(1'b1);
        xfer(19'h100, 20'd2, 0, 0);

        // start while busy
        xfer(19'h20, 20'd8, 0, 3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
